range_sequence_generator: RTL and testbench

- Parametrised successor to the fixed-range search sequence source.
- Emits search words {zero pad, fixed prefix, counter} over a run-time programmable range [first, last] with a programmable stride.
- Output uses a valid/ready handshake, so downstream search cores can apply backpressure.
- Supports restart by start pulse, sticky done, and a transferred-beat count for firmware readback.

---
 rtl/range_sequence_generator_if.sv | 42 ++++
 rtl/range_sequence_generator.sv | 88 ++++++++
 tb/tb_range_sequence_generator.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/range_sequence_generator_if.sv
// Handshake and configuration bundle for range_sequence_generator.
// The i_abort wire exists only when SEQGEN_ABORT_EN is defined.
interface range_sequence_generator_if #(
  parameter int SEQ_WIDTH = 16,
  parameter int FIX_WIDTH = 2,
  parameter int PAD_WIDTH = 2
);
  localparam int CNT_W = SEQ_WIDTH - FIX_WIDTH - PAD_WIDTH;

  logic                 i_start;
  logic [CNT_W-1:0]     i_first;
  logic [CNT_W-1:0]     i_last;
  logic [CNT_W-1:0]     i_step;
  logic [FIX_WIDTH-1:0] i_fix;
  logic [SEQ_WIDTH-1:0] o_seq;
  logic                 o_valid;
  logic                 i_ready;
  logic                 o_busy;
  logic                 o_done;
  logic [CNT_W:0]       o_count;
`ifdef SEQGEN_ABORT_EN
  logic                 i_abort;
`endif

  // Firmware / downstream side: drives config, start and ready.
  modport master (
    output i_start, i_first, i_last, i_step, i_fix, i_ready,
`ifdef SEQGEN_ABORT_EN
    output i_abort,
`endif
    input  o_seq, o_valid, o_busy, o_done, o_count
  );

  // Generator side.
  modport slave (
    input  i_start, i_first, i_last, i_step, i_fix, i_ready,
`ifdef SEQGEN_ABORT_EN
    input  i_abort,
`endif
    output o_seq, o_valid, o_busy, o_done, o_count
  );
endinterface

// File: rtl/range_sequence_generator.sv
// Range sequence generator: emits {zero pad, fixed prefix, counter} words
// over a programmable inclusive range [first, last] with a programmable
// stride, using a valid/ready handshake. The counter never wraps.
// Optional run abort input is enabled by defining SEQGEN_ABORT_EN.
module range_sequence_generator #(
  parameter int SEQ_WIDTH = 16,
  parameter int FIX_WIDTH = 2,
  parameter int PAD_WIDTH = 2
) (
  input  logic clk,
  input  logic rst,
  range_sequence_generator_if.slave bus
);
  localparam int CNT_W = SEQ_WIDTH - FIX_WIDTH - PAD_WIDTH;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]           state;
  logic [CNT_W-1:0]     counter;
  logic [CNT_W-1:0]     last_q;
  logic [CNT_W-1:0]     step_q;
  logic [FIX_WIDTH-1:0] fix_q;
  logic [CNT_W:0]       count_q;
  logic [CNT_W:0]       nxt_sum;
  logic                 range_end;
  logic                 fire;
  logic                 abort_req;

  // The extra MSB of the sum catches a carry so the counter can never wrap.
  assign nxt_sum   = {1'b0, counter} + {1'b0, step_q};
  assign range_end = (nxt_sum > {1'b0, last_q});
  assign fire      = (state == ST_RUN) && bus.i_ready;

`ifdef SEQGEN_ABORT_EN
  assign abort_req = bus.i_abort;
`else
  assign abort_req = 1'b0;
`endif

  assign bus.o_seq   = SEQ_WIDTH'({fix_q, counter});
  assign bus.o_valid = (state == ST_RUN);
  assign bus.o_busy  = (state == ST_RUN);
  assign bus.o_done  = (state == ST_DONE);
  assign bus.o_count = count_q;

  // Run control: latch config on start, advance on each transfer, stop at range end or abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      counter <= '0;
      last_q  <= '0;
      step_q  <= '0;
      fix_q   <= '0;
      count_q <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.i_start) begin
            last_q  <= bus.i_last;
            step_q  <= (bus.i_step == '0) ? CNT_W'(1) : bus.i_step;
            fix_q   <= bus.i_fix;
            count_q <= '0;
            if (bus.i_first <= bus.i_last) begin
              counter <= bus.i_first;
              state   <= ST_RUN;
            end else begin
              state   <= ST_DONE;
            end
          end
        end
        ST_RUN: begin
          if (fire) begin
            count_q <= count_q + (CNT_W+1)'(1);
            if (!range_end) begin
              counter <= nxt_sum[CNT_W-1:0];
            end
          end
          if (abort_req || (fire && range_end)) begin
            state <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_range_sequence_generator.sv
// Scoreboard bench for range_sequence_generator (SEQ_WIDTH=16, FIX=2, PAD=2,
// so the counter field is 12 bits). Abort checks compile in with SEQGEN_ABORT_EN.
module tb_range_sequence_generator;
  logic clk = 1'b0;
  logic rst = 1'b1;

  range_sequence_generator_if #(.SEQ_WIDTH(16), .FIX_WIDTH(2), .PAD_WIDTH(2)) bus ();

  range_sequence_generator #(.SEQ_WIDTH(16), .FIX_WIDTH(2), .PAD_WIDTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;
  int cycle = 0;
  int startCycle = 0;
  int lastFireCycle = 0;
  logic [15:0] q[$];
  logic abortSig = 1'b0;
  bit usePattern = 1'b0;
  logic [3:0] readyPat = 4'b1001;
  bit prevStall = 1'b0;
  logic [15:0] prevSeq = '0;

`ifdef SEQGEN_ABORT_EN
  assign bus.i_abort = abortSig;
`endif

  // Free-running clock.
  always #5 clk = ~clk;

  // Cycle counter used for latency checks.
  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
    end
  endtask

  task automatic pushBeat(input logic [1:0] fix, input logic [11:0] cnt);
    q.push_back({2'b00, fix, cnt});
  endtask

  task automatic applyStimulus(input logic [11:0] first, input logic [11:0] last,
                               input logic [11:0] step, input logic [1:0] fix);
    bus.i_first = first;
    bus.i_last  = last;
    bus.i_step  = step;
    bus.i_fix   = fix;
    bus.i_start = 1'b1;
    startCycle  = cycle;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
  endtask

  task automatic waitDone(input int expCount, input bit degenerate);
    bit seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.o_done) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
      if (usePattern) bus.i_ready = readyPat[(i + 1) % 4];
    end
    checkOutput("done_timeout", 32'(seen), 1);
    if (seen) begin
      if (degenerate) checkOutput("done_latency_from_start", cycle - startCycle, 1);
      else            checkOutput("done_latency_from_last_beat", cycle - lastFireCycle, 1);
      checkOutput("count_at_done", 32'(bus.o_count), expCount);
      checkOutput("valid_at_done", 32'(bus.o_valid), 0);
      checkOutput("busy_at_done", 32'(bus.o_busy), 0);
      checkOutput("missing_beats", q.size(), 0);
    end
    q.delete();
    usePattern  = 1'b0;
    bus.i_ready = 1'b1;
  endtask

  // Monitor: pops the scoreboard on every handshake and checks stall stability.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prevStall = 1'b0;
      end else begin
        if (prevStall) begin
          checkOutput("stall_valid_held", 32'(bus.o_valid), 1);
          checkOutput("stall_seq_held", 32'(bus.o_seq), 32'(prevSeq));
        end
        if (bus.o_valid && bus.i_ready) begin
          lastFireCycle = cycle;
          if (q.size() == 0) begin
            checkOutput("unexpected_beat", 32'(bus.o_seq), 32'hFFFF_FFFF);
          end else begin
            checkOutput("beat_seq", 32'(bus.o_seq), 32'(q.pop_front()));
          end
        end
        prevStall = bus.o_valid && !bus.i_ready && !abortSig;
        prevSeq   = bus.o_seq;
      end
    end
  end

  // Directed stimulus sequence.
  initial begin
    bus.i_start = 1'b0;
    bus.i_first = '0;
    bus.i_last  = '0;
    bus.i_step  = '0;
    bus.i_fix   = '0;
    bus.i_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_seq", 32'(bus.o_seq), 0);
    checkOutput("reset_valid", 32'(bus.o_valid), 0);
    checkOutput("reset_busy", 32'(bus.o_busy), 0);
    checkOutput("reset_done", 32'(bus.o_done), 0);
    checkOutput("reset_count", 32'(bus.o_count), 0);

    // Basic range 0..3, prefix 2'b10 -> 0x2000..0x2003.
    @(posedge clk); #1;
    q.push_back(16'h2000); q.push_back(16'h2001);
    q.push_back(16'h2002); q.push_back(16'h2003);
    applyStimulus(12'd0, 12'd3, 12'd1, 2'b10);
    waitDone(4, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("done_sticky", 32'(bus.o_done), 1);
    checkOutput("count_hold", 32'(bus.o_count), 4);
    checkOutput("seq_hold", 32'(bus.o_seq), 32'h2003);

    // Stride 3 over 0..10 -> 0,3,6,9 with prefix 01.
    @(posedge clk); #1;
    q.push_back(16'h1000); q.push_back(16'h1003);
    q.push_back(16'h1006); q.push_back(16'h1009);
    applyStimulus(12'd0, 12'd10, 12'd3, 2'b01);
    waitDone(4, 1'b0);

    // Stride 0 behaves as 1 -> eleven beats 0..10.
    @(posedge clk); #1;
    for (int k = 0; k <= 10; k++) pushBeat(2'b01, 12'(k));
    applyStimulus(12'd0, 12'd10, 12'd0, 2'b01);
    waitDone(11, 1'b0);

    // Backpressure with ready pattern 1,0,0,1 over 0..5.
    @(posedge clk); #1;
    for (int k = 0; k <= 5; k++) pushBeat(2'b11, 12'(k));
    usePattern = 1'b1;
    applyStimulus(12'd0, 12'd5, 12'd1, 2'b11);
    bus.i_ready = readyPat[0];
    waitDone(6, 1'b0);

    // No-wrap boundary: 4090, 4094, then stop (4098 would wrap to 2).
    @(posedge clk); #1;
    q.push_back(16'h0FFA); q.push_back(16'h0FFE);
    applyStimulus(12'd4090, 12'd4095, 12'd4, 2'b00);
    waitDone(2, 1'b0);

    // Single beat at the top of the counter range.
    @(posedge clk); #1;
    q.push_back(16'h2FFF);
    applyStimulus(12'd4095, 12'd4095, 12'd1, 2'b10);
    waitDone(1, 1'b0);

    // Degenerate range 5..3: done one cycle after start, no beats.
    @(posedge clk); #1;
    applyStimulus(12'd5, 12'd3, 12'd1, 2'b10);
    waitDone(0, 1'b1);

    // Restart after degenerate run, with a start pulse mid-run that must be ignored.
    @(posedge clk); #1;
    for (int k = 0; k <= 7; k++) pushBeat(2'b11, 12'(k));
    applyStimulus(12'd0, 12'd7, 12'd1, 2'b11);
    @(negedge clk);
    checkOutput("restart_done_cleared", 32'(bus.o_done), 0);
    checkOutput("restart_busy", 32'(bus.o_busy), 1);
    @(posedge clk); #1;
    applyStimulus(12'd100, 12'd200, 12'd1, 2'b01);
    waitDone(8, 1'b0);

    // Reset after two beats of a 0..10 run.
    @(posedge clk); #1;
    q.push_back(16'h1000); q.push_back(16'h1001);
    applyStimulus(12'd0, 12'd10, 12'd1, 2'b01);
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrun_reset_seq", 32'(bus.o_seq), 0);
    checkOutput("midrun_reset_valid", 32'(bus.o_valid), 0);
    checkOutput("midrun_reset_busy", 32'(bus.o_busy), 0);
    checkOutput("midrun_reset_done", 32'(bus.o_done), 0);
    checkOutput("midrun_reset_count", 32'(bus.o_count), 0);
    checkOutput("midrun_reset_beats_seen", q.size(), 0);
    q.delete();

`ifdef SEQGEN_ABORT_EN
    // Abort after two beats with ready low on the abort cycle.
    @(posedge clk); #1;
    q.push_back(16'h1000); q.push_back(16'h1001);
    applyStimulus(12'd0, 12'd10, 12'd1, 2'b01);
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    @(posedge clk); #1;
    abortSig    = 1'b1;
    bus.i_ready = 1'b0;
    @(posedge clk); #1;
    abortSig    = 1'b0;
    bus.i_ready = 1'b1;
    @(negedge clk);
    checkOutput("abort_done", 32'(bus.o_done), 1);
    checkOutput("abort_count", 32'(bus.o_count), 2);
    checkOutput("abort_valid", 32'(bus.o_valid), 0);
    checkOutput("abort_busy", 32'(bus.o_busy), 0);
    checkOutput("abort_beats_seen", q.size(), 0);
    q.delete();
`endif

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
